// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the ram32x4 access controller.
package ram_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEPTH      = 32;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StClear   = 3'd1,
    StWrite   = 3'd2,
    StScanReq = 3'd3,
    StScanCap = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/scan_prescaler.sv
// Divides the clock down to a one-cycle scan tick every SCAN_DIV cycles while enabled.
module scan_prescaler #(
  parameter int unsigned SCAN_DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Free-running count while enabled; parked at zero otherwise so a re-enable starts a full period.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tick = enable && (cnt_q == LAST);

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Sequencing front-end for ram32x4: buffered single writes, whole-memory clear and rolling readout.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned SCAN_DIV = 50_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_clear,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              scan_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              busy
);

  // Clear walks every address; the last one is all-ones for a power-of-two depth.
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] wbuf_addr_q, wbuf_addr_d;
  logic [DATA_W-1:0] wbuf_data_q, wbuf_data_d;
  logic              wr_pend_q, wr_pend_d;
  logic              scan_pend_q, scan_pend_d;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              disp_valid_q, disp_valid_d;

  logic scan_tick;
  logic wr_take;
  logic wr_go;
  logic scan_go;

  scan_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (scan_en),
    .tick   (scan_tick)
  );

  // Requests arriving this cycle count as pending so IDLE can act on them without a bubble.
  assign wr_take = wr_req && (state_q != StClear);
  assign wr_go   = wr_take || wr_pend_q;
  assign scan_go = scan_tick || scan_pend_q;

  // Next-state, pending buffers, scan pointer and display capture.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    ptr_d        = ptr_q;
    wbuf_addr_d  = wbuf_addr_q;
    wbuf_data_d  = wbuf_data_q;
    wr_pend_d    = wr_pend_q;
    scan_pend_d  = scan_pend_q;
    disp_addr_d  = disp_addr_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_clear) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end else if (wr_go) begin
          state_d = StWrite;
        end else if (scan_go) begin
          state_d = StScanReq;
        end
      end
      StClear: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        ptr_d     = '0;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = StIdle;
        end
      end
      StWrite: begin
        state_d = StIdle;
      end
      StScanReq: begin
        state_d = StScanCap;
      end
      StScanCap: begin
        disp_addr_d  = ptr_q;
        disp_data_d  = ram_q;
        disp_valid_d = 1'b1;
        ptr_d        = ptr_q + 1'b1;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A new request wins over retiring the old one, so a request landing in WRITE is not lost.
    if (wr_take) begin
      wr_pend_d   = 1'b1;
      wbuf_addr_d = wr_addr;
      wbuf_data_d = wr_data;
    end else if (state_q == StWrite) begin
      wr_pend_d = 1'b0;
    end

    // Entering SCAN_REQ consumes the tick; further ticks only re-set a single flag.
    if ((state_q == StIdle) && (state_d == StScanReq)) begin
      scan_pend_d = 1'b0;
    end else if (scan_tick) begin
      scan_pend_d = 1'b1;
    end
  end

  // RAM port drive decoded from the current state; idle-low outside CLEAR/WRITE/SCAN_REQ.
  always_comb begin
    ram_addr = '0;
    ram_data = '0;
    ram_wren = 1'b0;
    case (state_q)
      StClear: begin
        ram_addr = clr_cnt_q;
        ram_wren = 1'b1;
      end
      StWrite: begin
        ram_addr = wbuf_addr_q;
        ram_data = wbuf_data_q;
        ram_wren = 1'b1;
      end
      StScanReq: begin
        ram_addr = ptr_q;
      end
      default: begin
        ram_addr = '0;
      end
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign disp_addr  = disp_addr_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;

  // State and datapath registers; reset aborts any clear in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      clr_cnt_q    <= '0;
      ptr_q        <= '0;
      wbuf_addr_q  <= '0;
      wbuf_data_q  <= '0;
      wr_pend_q    <= 1'b0;
      scan_pend_q  <= 1'b0;
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      ptr_q        <= ptr_d;
      wbuf_addr_q  <= wbuf_addr_d;
      wbuf_data_q  <= wbuf_data_d;
      wr_pend_q    <= wr_pend_d;
      scan_pend_q  <= scan_pend_d;
      disp_addr_q  <= disp_addr_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
    end
  end

endmodule
